// File: rtl/load_store_unit_if.sv
// Bus bundle between the CPU datapath / Memory and the load/store unit.
// The unit uses the slave modport; the requester and memory side use master.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic        req_byte;
  logic        req_signed;
  logic [15:0] req_addr;
  logic [15:0] req_wdata;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_rdata;
  logic        resp_err;
  logic        memwrite;
  logic        memread;
  logic [15:0] address;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport slave (
    input  req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
    input  resp_ready, readdata,
    output req_ready, resp_valid, resp_rdata, resp_err,
    output memwrite, memread, address, writedata
  );

  modport master (
    output req_valid, req_write, req_byte, req_signed, req_addr, req_wdata,
    output resp_ready, readdata,
    input  req_ready, resp_valid, resp_rdata, resp_err,
    input  memwrite, memread, address, writedata
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store front end for the 16-bit word-addressed Memory: one request at a
// time, byte stores done as read-modify-write, byte loads zero/sign-extended.
module load_store_unit #(
  parameter int READ_LATENCY = 1
) (
  input logic             clk,
  input logic             rst,
  load_store_unit_if.slave bus
);

  typedef enum logic [2:0] {IDLE, READ, WRITE, RESP, ERR} state_t;

  localparam logic [3:0] LAST_CNT = 4'(READ_LATENCY - 1);

  state_t      state_r;
  logic [15:0] addr_q;
  logic [7:0]  wdata_q;
  logic        write_q;
  logic        byte_q;
  logic        signed_q;
  logic [3:0]  cnt_r;

  logic        memread_r;
  logic        memwrite_r;
  logic [15:0] writedata_r;
  logic        resp_valid_r;
  logic        resp_err_r;
  logic [15:0] resp_rdata_r;

  function automatic logic [15:0] merge_byte(input logic [15:0] word,
                                             input logic [7:0]  b,
                                             input logic        hi);
    logic [15:0] m;
    m = word;
    if (hi) begin
      m[15:8] = b;
    end else begin
      m[7:0] = b;
    end
    return m;
  endfunction

  function automatic logic [15:0] load_result(input logic [15:0] word,
                                              input logic        by,
                                              input logic        sg,
                                              input logic        hi);
    logic [7:0]  b;
    logic [15:0] r;
    b = hi ? word[15:8] : word[7:0];
    if (!by) begin
      r = word;
    end else if (sg) begin
      r = {{8{b[7]}}, b};
    end else begin
      r = {8'h00, b};
    end
    return r;
  endfunction

  // Output mapping; the word address is a rewire of the latched byte address.
  assign bus.req_ready  = (state_r == IDLE) && !rst;
  assign bus.memread    = memread_r;
  assign bus.memwrite   = memwrite_r;
  assign bus.address    = {1'b0, addr_q[15:1]};
  assign bus.writedata  = writedata_r;
  assign bus.resp_valid = resp_valid_r;
  assign bus.resp_err   = resp_err_r;
  assign bus.resp_rdata = resp_rdata_r;

  // Request FSM with registered memory-side and response outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r      <= IDLE;
      addr_q       <= 16'h0000;
      wdata_q      <= 8'h00;
      write_q      <= 1'b0;
      byte_q       <= 1'b0;
      signed_q     <= 1'b0;
      cnt_r        <= 4'd0;
      memread_r    <= 1'b0;
      memwrite_r   <= 1'b0;
      writedata_r  <= 16'h0000;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_rdata_r <= 16'h0000;
    end else begin
      case (state_r)
        IDLE: begin
          if (bus.req_valid) begin
            addr_q   <= bus.req_addr;
            wdata_q  <= bus.req_wdata[7:0];
            write_q  <= bus.req_write;
            byte_q   <= bus.req_byte;
            signed_q <= bus.req_signed;
            cnt_r    <= 4'd0;
            if (!bus.req_byte && bus.req_addr[0]) begin
              state_r      <= ERR;
              resp_valid_r <= 1'b1;
              resp_err_r   <= 1'b1;
              resp_rdata_r <= 16'h0000;
            end else if (bus.req_write && !bus.req_byte) begin
              state_r     <= WRITE;
              memwrite_r  <= 1'b1;
              writedata_r <= bus.req_wdata;
            end else begin
              state_r   <= READ;
              memread_r <= 1'b1;
            end
          end
        end
        READ: begin
          if (cnt_r == LAST_CNT) begin
            memread_r <= 1'b0;
            // Byte stores reuse the read word to build the merged write.
            if (write_q) begin
              state_r     <= WRITE;
              memwrite_r  <= 1'b1;
              writedata_r <= merge_byte(bus.readdata, wdata_q, addr_q[0]);
            end else begin
              state_r      <= RESP;
              resp_valid_r <= 1'b1;
              resp_rdata_r <= load_result(bus.readdata, byte_q, signed_q, addr_q[0]);
            end
          end else begin
            cnt_r <= cnt_r + 4'd1;
          end
        end
        WRITE: begin
          memwrite_r   <= 1'b0;
          state_r      <= RESP;
          resp_valid_r <= 1'b1;
          resp_rdata_r <= 16'h0000;
        end
        RESP, ERR: begin
          if (bus.resp_ready) begin
            state_r      <= IDLE;
            resp_valid_r <= 1'b0;
            resp_err_r   <= 1'b0;
            resp_rdata_r <= 16'h0000;
          end
        end
        default: begin
          state_r      <= IDLE;
          memread_r    <= 1'b0;
          memwrite_r   <= 1'b0;
          resp_valid_r <= 1'b0;
          resp_err_r   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a behavioural word memory behind it.
module tb_load_store_unit;

  typedef struct {
    logic [15:0] rdata;
    logic        err;
    int          lat;
    int          nrd;
    int          nwr;
  } exp_t;

  logic clk;
  logic rst;
  load_store_unit_if bus ();

  load_store_unit #(.READ_LATENCY(1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [15:0] mem [0:32767];
  exp_t        sb [$];
  int          errors = 0;
  int          checks = 0;
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          rv_cnt = 0;
  int          both_cnt = 0;
  logic [15:0] wr_addr = 16'h0000;
  logic [15:0] wr_data = 16'h0000;
  logic [15:0] model [0:7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.readdata = mem[bus.address[14:0]];

  // Memory model plus activity counters sampled at each rising edge.
  always @(posedge clk) begin
    if (bus.memread) rd_cnt <= rd_cnt + 1;
    if (bus.memwrite) begin
      wr_cnt <= wr_cnt + 1;
      wr_addr <= bus.address;
      wr_data <= bus.writedata;
      mem[bus.address[14:0]] <= bus.writedata;
    end
    if (bus.resp_valid) rv_cnt <= rv_cnt + 1;
    if (bus.memread && bus.memwrite) both_cnt <= both_cnt + 1;
  end

  task automatic issue(input logic wr, input logic by, input logic sg,
                       input logic [15:0] addr, input logic [15:0] wd,
                       input logic [15:0] exp_rdata, input logic exp_err,
                       input int exp_lat, input int exp_nrd, input int exp_nwr,
                       input int hold, input string name);
    exp_t e_in;
    exp_t e;
    int n;
    int rd0;
    int wr0;
    logic [15:0] snap_d;
    logic snap_e;
    e_in.rdata = exp_rdata;
    e_in.err = exp_err;
    e_in.lat = exp_lat;
    e_in.nrd = exp_nrd;
    e_in.nwr = exp_nwr;
    sb.push_back(e_in);
    @(negedge clk);
    bus.req_write = wr;
    bus.req_byte = by;
    bus.req_signed = sg;
    bus.req_addr = addr;
    bus.req_wdata = wd;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (!bus.req_ready) begin
      errors++;
      $display("FAIL %s req_ready: got 0 want 1 within 20 cycles", name);
      bus.req_valid = 1'b0;
      void'(sb.pop_front());
      return;
    end
    rd0 = rd_cnt;
    wr0 = wr_cnt;
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    n = 1;
    while (!bus.resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    e = sb.pop_front();
    checks++;
    if (bus.resp_valid !== 1'b1) begin
      errors++;
      $display("FAIL %s resp_valid: got %b want 1 within 40 cycles", name, bus.resp_valid);
      return;
    end
    checks++;
    if (n !== e.lat) begin
      errors++;
      $display("FAIL %s latency: got %0d want %0d", name, n, e.lat);
    end
    checks++;
    if (bus.resp_rdata !== e.rdata) begin
      errors++;
      $display("FAIL %s resp_rdata: got %h want %h", name, bus.resp_rdata, e.rdata);
    end
    checks++;
    if (bus.resp_err !== e.err) begin
      errors++;
      $display("FAIL %s resp_err: got %b want %b", name, bus.resp_err, e.err);
    end
    snap_d = bus.resp_rdata;
    snap_e = bus.resp_err;
    for (int k = 0; k < hold; k++) begin
      @(negedge clk);
      checks++;
      if ({bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.req_ready} !== {1'b1, snap_e, snap_d, 1'b0}) begin
        errors++;
        $display("FAIL %s hold%0d: got v=%b e=%b d=%h rdy=%b want v=1 e=%b d=%h rdy=0",
                 name, k, bus.resp_valid, bus.resp_err, bus.resp_rdata, bus.req_ready, snap_e, snap_d);
      end
    end
    bus.resp_ready = 1'b1;
    @(negedge clk);
    bus.resp_ready = 1'b0;
    checks++;
    if ({bus.resp_valid, bus.req_ready} !== 2'b01) begin
      errors++;
      $display("FAIL %s after accept: got v=%b rdy=%b want v=0 rdy=1", name, bus.resp_valid, bus.req_ready);
    end
    checks++;
    if ((rd_cnt - rd0) !== e.nrd || (wr_cnt - wr0) !== e.nwr) begin
      errors++;
      $display("FAIL %s mem pulses: got rd=%0d wr=%0d want rd=%0d wr=%0d",
               name, rd_cnt - rd0, wr_cnt - wr0, e.nrd, e.nwr);
    end
  endtask

  task automatic check_write(input logic [15:0] a, input logic [15:0] d, input string name);
    checks++;
    if (wr_addr !== a || wr_data !== d) begin
      errors++;
      $display("FAIL %s write: got addr=%h data=%h want addr=%h data=%h", name, wr_addr, wr_data, a, d);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.resp_valid, bus.resp_err, bus.memread, bus.memwrite,
         bus.resp_rdata, bus.address, bus.writedata} !== 53'd0) begin
      errors++;
      $display("FAIL reset outputs: got rdy=%b v=%b e=%b rd=%b wr=%b d=%h a=%h wd=%h want all 0",
               bus.req_ready, bus.resp_valid, bus.resp_err, bus.memread, bus.memwrite,
               bus.resp_rdata, bus.address, bus.writedata);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if ({bus.req_ready, bus.memread, bus.memwrite} !== 3'b100) begin
      errors++;
      $display("FAIL reset release: got rdy=%b rd=%b wr=%b want 1 0 0",
               bus.req_ready, bus.memread, bus.memwrite);
    end
  endtask

  task automatic test_word_store_load();
    issue(1'b1, 1'b0, 1'b0, 16'h0000, 16'h1111, 16'h0000, 1'b0, 2, 0, 1, 0, "wstore0");
    check_write(16'h0000, 16'h1111, "wstore0");
    issue(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h1111, 1'b0, 2, 1, 0, 0, "wload0");
  endtask

  task automatic test_byte_rmw();
    issue(1'b1, 1'b0, 1'b0, 16'h1234, 16'h9999, 16'h0000, 1'b0, 2, 0, 1, 0, "preload91a");
    issue(1'b1, 1'b1, 1'b0, 16'h1235, 16'h00AB, 16'h0000, 1'b0, 3, 1, 1, 0, "bstore_hi");
    check_write(16'h091A, 16'hAB99, "bstore_hi");
    issue(1'b1, 1'b1, 1'b0, 16'h1234, 16'hFFCD, 16'h0000, 1'b0, 3, 1, 1, 0, "bstore_lo");
    check_write(16'h091A, 16'hABCD, "bstore_lo");
    issue(1'b0, 1'b0, 1'b0, 16'h1234, 16'h0000, 16'hABCD, 1'b0, 2, 1, 0, 0, "wload91a");
  endtask

  task automatic test_byte_loads();
    issue(1'b1, 1'b0, 1'b0, 16'h0000, 16'h80F0, 16'h0000, 1'b0, 2, 0, 1, 0, "preload0");
    issue(1'b0, 1'b1, 1'b1, 16'h0000, 16'h0000, 16'hFFF0, 1'b0, 2, 1, 0, 0, "bload_lo_s");
    issue(1'b0, 1'b1, 1'b0, 16'h0001, 16'h0000, 16'h0080, 1'b0, 2, 1, 0, 0, "bload_hi_u");
    issue(1'b0, 1'b1, 1'b1, 16'h0001, 16'h0000, 16'hFF80, 1'b0, 2, 1, 0, 0, "bload_hi_s");
    issue(1'b0, 1'b1, 1'b0, 16'h0000, 16'h0000, 16'h00F0, 1'b0, 2, 1, 0, 0, "bload_lo_u");
  endtask

  task automatic test_error_backpressure();
    issue(1'b0, 1'b0, 1'b0, 16'h0003, 16'h0000, 16'h0000, 1'b1, 1, 0, 0, 3, "misload");
    issue(1'b1, 1'b0, 1'b0, 16'h0005, 16'h5555, 16'h0000, 1'b1, 1, 0, 0, 0, "misstore");
    issue(1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 16'h80F0, 1'b0, 2, 1, 0, 3, "load_bp");
  endtask

  task automatic test_wrap();
    issue(1'b1, 1'b0, 1'b0, 16'hFFFE, 16'h1234, 16'h0000, 1'b0, 2, 0, 1, 0, "preload7fff");
    issue(1'b1, 1'b1, 1'b0, 16'hFFFF, 16'h005A, 16'h0000, 1'b0, 3, 1, 1, 0, "wrap_bstore");
    check_write(16'h7FFF, 16'h5A34, "wrap_bstore");
    issue(1'b0, 1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h005A, 1'b0, 2, 1, 0, 0, "wrap_bload");
  endtask

  task automatic test_back_to_back();
    logic [15:0] d;
    int idx;
    for (int i = 0; i < 8; i++) begin
      d = 16'($urandom);
      model[i] = d;
      issue(1'b1, 1'b0, 1'b0, 16'h0200 + 16'(i * 2), d, 16'h0000, 1'b0, 2, 0, 1, 0, "b2b_store");
    end
    for (int i = 0; i < 8; i++) begin
      idx = int'($urandom_range(7, 0));
      issue(1'b0, 1'b0, 1'b0, 16'h0200 + 16'(idx * 2), 16'h0000, model[idx], 1'b0, 2, 1, 0, 0, "b2b_load");
    end
  endtask

  task automatic test_mid_reset();
    int wr0;
    int rv0;
    int n;
    wr0 = wr_cnt;
    rv0 = rv_cnt;
    @(negedge clk);
    bus.req_write = 1'b1;
    bus.req_byte = 1'b1;
    bus.req_signed = 1'b0;
    bus.req_addr = 16'h0401;
    bus.req_wdata = 16'h00EE;
    bus.req_valid = 1'b1;
    n = 0;
    while (!bus.req_ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    @(posedge clk);
    @(negedge clk);
    bus.req_valid = 1'b0;
    checks++;
    if (bus.memread !== 1'b1) begin
      errors++;
      $display("FAIL midrst memread in READ: got %b want 1", bus.memread);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({bus.memread, bus.memwrite, bus.resp_valid, bus.req_ready} !== 4'b0000) begin
      errors++;
      $display("FAIL midrst outputs: got rd=%b wr=%b v=%b rdy=%b want 0 0 0 0",
               bus.memread, bus.memwrite, bus.resp_valid, bus.req_ready);
    end
    rst = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (wr_cnt !== wr0 || rv_cnt !== rv0 || bus.req_ready !== 1'b1) begin
      errors++;
      $display("FAIL midrst aftermath: got writes=%0d resps=%0d rdy=%b want writes=%0d resps=%0d rdy=1",
               wr_cnt, rv_cnt, bus.req_ready, wr0, rv0);
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_byte = 1'b0;
    bus.req_signed = 1'b0;
    bus.req_addr = 16'h0000;
    bus.req_wdata = 16'h0000;
    bus.resp_ready = 1'b0;
    test_reset();
    test_word_store_load();
    test_byte_rmw();
    test_byte_loads();
    test_error_backpressure();
    test_wrap();
    test_back_to_back();
    test_mid_reset();
    checks++;
    if (both_cnt !== 0) begin
      errors++;
      $display("FAIL read_write_overlap: got %0d cycles want 0", both_cnt);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

Load/store front end placed directly upstream of the 16-bit `Memory` block. It accepts one load or store request at a time from the CPU datapath over a valid/ready handshake. It converts each byte address into a word address, drives `memread`/`memwrite`/`address`/`writedata` to `Memory`, and returns load data or completion on a response handshake. Byte stores are performed as read-modify-write. Byte loads are zero- or sign-extended.

## Interface
- `READ_LATENCY`, default 1: number of cycles `memread` is held before `readdata` is sampled; legal range 1–15.
- `clk`  in  1  system clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_write`  in  1  1 = store, 0 = load.
- `req_byte`  in  1  1 = byte access, 0 = 16-bit word access.
- `req_signed`  in  1  byte loads only: 1 = sign-extend, 0 = zero-extend.
- `req_addr`  in  16  byte address.
- `req_wdata`  in  16  store data; byte stores use `[7:0]`.
- `resp_valid`  out  1  response present.
- `resp_ready`  in  1  consumer accepts response.
- `resp_rdata`  out  16  load result; 0 for stores and errors.
- `resp_err`  out  1  misaligned word access.
- `memwrite`  out  1  to `Memory`.
- `memread`  out  1  to `Memory`.
- `address`  out  16  word address to `Memory`: `{1'b0, req_addr[15:1]}`.
- `writedata`  out  16  to `Memory`.
- `readdata`  in  16  from `Memory`.

## Operation
- The FSM has five states: IDLE, READ, WRITE, RESP, ERR. Registered request fields are `addr_q`, `wdata_q`, `write_q`, `byte_q`, `signed_q`.
- `req_ready` = (state == IDLE) and not `rst`. A handshake occurs at an edge where `req_valid` and `req_ready` are both 1; the request fields are latched at that edge.
- Transitions from IDLE on handshake:
  - Word access with `req_addr[0]` = 1 → ERR.
  - Word store → WRITE.
  - Any load, or a byte store → READ.
- READ:
  - `memread` = 1 and `address` = word address.
  - A 4-bit counter counts READ_LATENCY cycles. At the final edge, `readdata` is captured into `rd_q`.
  - Load → RESP. Byte store → WRITE.
- WRITE:
  - `memwrite` = 1 for exactly one cycle.
  - `writedata` = `wdata_q` for a word store.
  - For a byte store, `writedata` = `rd_q` with byte `addr_q[0]` replaced by `wdata_q[7:0]`. Byte 0 is `[7:0]`; byte 1 is `[15:8]`.
  - Next state is RESP.
- `resp_rdata` formation:
  - Word load: `rd_q`.
  - Byte load: the selected byte, with bits `[15:8]` = 0, or set to bit 7 of the byte when `signed_q` = 1.
  - Stores and errors: 0.
- RESP and ERR:
  - `resp_valid` = 1; `resp_err` = 1 in ERR only.
  - No memory access is made in ERR.
  - The state is held until `resp_ready` = 1, then → IDLE.
- `memread` and `memwrite` are never both 1 in the same cycle. Both are 0 in IDLE, RESP and ERR.
- Address wrap: byte address 0xFFFF maps to word 0x7FFF, high byte. There is no carry into bit 15 of `address`.
- Reset:
  - All outputs are 0 while `rst` is high. This includes `req_ready`, so the unit presents 0 on every output during reset.
  - Asserting reset mid-operation returns the FSM to IDLE at that edge. `memread`/`memwrite` drop, the in-flight request is discarded and no response is issued. A partially completed byte store performs no write.

## Timing
- All memory-side outputs and response outputs are registered. `req_ready` is decoded from the state register.
- With handshake at edge N and READ_LATENCY = L:
  - Word load: READ for cycles N+1…N+L; `resp_valid` from cycle N+L+1.
  - Word store: WRITE in cycle N+1; `resp_valid` from cycle N+2.
  - Byte store: READ for cycles N+1…N+L, WRITE in cycle N+L+1; `resp_valid` from cycle N+L+2.
  - Misaligned access: `resp_valid` with `resp_err` from cycle N+1.
- When the response is accepted at edge M, `req_ready` = 1 in cycle M+1. Back-to-back throughput is therefore one request per (latency + 2) cycles minimum.
- `address` and `writedata` remain stable for the whole READ or WRITE interval.
- The response outputs remain stable while `resp_valid` = 1 and `resp_ready` = 0.

## Test plan
- Reset: hold `rst` for 2 cycles. Every output must be 0. After release, `req_ready` = 1 and `memread` = `memwrite` = 0.
- Word store then load:
  - Store 0x1111 at byte address 0x0000: `memwrite` pulses once with `address` = 0x0000 and `writedata` = 0x1111.
  - Load from 0x0000: `resp_rdata` = 0x1111, with `resp_valid` at N+2 (L = 1).
- Byte store read-modify-write:
  - Memory word 0x091A holds 0x9999. Store byte 0xAB to byte address 0x1235.
  - Required sequence: READ, then WRITE with `writedata` = 0xAB99; response at N+3.
- Byte loads from word 0x0000 holding 0x80F0:
  - Address 0x0000, `req_signed` = 1 → 0xFFF0.
  - Address 0x0001, `req_signed` = 0 → 0x0080.
- Error and backpressure:
  - Word load at 0x0003 → `resp_err` = 1 with no `memread`/`memwrite` pulse.
  - Hold `resp_ready` = 0 for 3 cycles: the response stays stable and `req_ready` stays 0.
- Reset mid-operation: assert `rst` during READ of a byte store. `memread` drops the next cycle, no `memwrite` ever pulses, and no `resp_valid` is issued.
